// File: rtl/rpc2_ctrl_axi_wr_data_router.sv
// rpc2_ctrl_axi_wr_data_router: N-channel AXI3 W-channel router into per-channel write-data FIFOs
//   clk, reset_n (async, active low)
//   AXI_W*            : AXI write-data channel, AXI_WREADY registered
//   wready_req/id/len : per-channel arm pulse, packed IDs and beats-1
//   wready_done       : per-channel completion pulse
//   wdat_wr_en/din    : per-channel FIFO write strobe, shared {last, strb, data}
//   wdat_pre_full     : per-channel FIFO has at most one free entry
//   err_unmatched     : pulse when an accepted beat matched no active channel
//   err_wlast         : pulse on WLAST/beat-count mismatch, only with RPC2_WR_ROUTER_WLAST_CHECK_EN
module rpc2_ctrl_axi_wr_data_router #(
  parameter int C_AXI_ID_WIDTH = 4,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int NUM_CH = 2,
  parameter int LEN_WIDTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [C_AXI_DATA_WIDTH-1:0]           AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]         AXI_WSTRB,
  input  logic                                  AXI_WLAST,
  input  logic                                  AXI_WVALID,
  input  logic [C_AXI_ID_WIDTH-1:0]             AXI_WID,
  output logic                                  AXI_WREADY,
  input  logic [NUM_CH-1:0]                     wready_req,
  input  logic [NUM_CH*C_AXI_ID_WIDTH-1:0]      wready_id,
  input  logic [NUM_CH*LEN_WIDTH-1:0]           wready_len,
  output logic [NUM_CH-1:0]                     wready_done,
  output logic [NUM_CH-1:0]                     wdat_wr_en,
  output logic [C_AXI_DATA_WIDTH+C_AXI_DATA_WIDTH/8:0] wdat_din,
  input  logic [NUM_CH-1:0]                     wdat_pre_full,
  output logic                                  err_unmatched,
  output logic                                  err_wlast
);
  localparam int FIFO_W = C_AXI_DATA_WIDTH + C_AXI_DATA_WIDTH/8 + 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  logic              acc;
  logic              last_bit;
  logic              err_wlast_d;
  logic              wready_d;
  logic [NUM_CH-1:0] act_d;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] zero;
  logic [NUM_CH-1:0] fin;
  logic [FIFO_W-1:0] din_d;
  assign acc = AXI_WVALID & AXI_WREADY;
  // isolate lowest set bit: lowest-index matching channel wins duplicate IDs
  assign sel = match & (~match + NUM_CH'(1));
  // next-state view drops channels finishing this edge and includes ones arming now
  assign wready_d = |act_d & ~|(act_d & wdat_pre_full);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t                    st_q;
    state_t                    st_d;
    logic [C_AXI_ID_WIDTH-1:0] id_q;
    logic [LEN_WIDTH-1:0]      cnt_q;
    assign match[i] = (st_q == ACTIVE) & (id_q == AXI_WID);
    assign zero[i]  = (cnt_q == '0);
    assign fin[i]   = acc & sel[i] & zero[i];
    assign act_d[i] = (st_d == ACTIVE);
    always_comb begin
      st_d = (st_q == IDLE) ? (wready_req[i] ? ACTIVE : IDLE) : (fin[i] ? IDLE : ACTIVE);
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st_q  <= IDLE;
        id_q  <= '0;
        cnt_q <= '0;
      end else begin
        st_q <= st_d;
        if (st_q == IDLE && wready_req[i]) begin
          id_q  <= wready_id[i*C_AXI_ID_WIDTH +: C_AXI_ID_WIDTH];
          cnt_q <= wready_len[i*LEN_WIDTH +: LEN_WIDTH];
        end else if (acc && sel[i] && !zero[i]) begin
          cnt_q <= cnt_q - LEN_WIDTH'(1);
        end
      end
    end
  end
`ifdef RPC2_WR_ROUTER_WLAST_CHECK_EN
  // the stored last bit follows the beat counter, not the master's WLAST
  assign last_bit    = |(sel & zero);
  assign err_wlast_d = acc & |match & (AXI_WLAST != last_bit);
`else
  assign last_bit    = AXI_WLAST;
  assign err_wlast_d = 1'b0;
`endif
  assign din_d = {last_bit, AXI_WSTRB, AXI_WDATA};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      AXI_WREADY    <= 1'b0;
      wdat_wr_en    <= '0;
      wdat_din      <= '0;
      wready_done   <= '0;
      err_unmatched <= 1'b0;
      err_wlast     <= 1'b0;
    end else begin
      AXI_WREADY    <= wready_d;
      wdat_wr_en    <= acc ? sel : '0;
      wdat_din      <= acc ? din_d : wdat_din;
      wready_done   <= fin;
      err_unmatched <= acc & ~|match;
      err_wlast     <= err_wlast_d;
    end
  end
endmodule
